// File: rtl/tt_um_serial_sum.sv
// Bit-serial WIDTH-bit adder tile: operands arrive LSB first, one bit per strobe,
// and the completed sum is presented in parallel. `SERIAL_SUM_SYNC_EN adds a 2-flop input synchronizer.
module tt_um_serial_sum #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Field order matches ui_in[3:0]: a_bit is bit 0, clear is bit 3.
    typedef struct packed {
        logic clear;
        logic strobe;
        logic b_bit;
        logic a_bit;
    } ctrl_t;

    ctrl_t            in_pre;
    ctrl_t            s0_q, s0_d;
    logic             s1_q, s1_d;
    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [7:0]       uo_q, uo_d;
    logic             carry_out_q, carry_out_d;

    logic             strobe_edge;
    logic             step_cin, step_s, step_c;

`ifdef SERIAL_SUM_SYNC_EN
    logic [1:0][3:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], ui_in[3:0]};
    end

    assign in_pre = ctrl_t'(sync_q[1]);
`else
    assign in_pre = ctrl_t'(ui_in[3:0]);
`endif

    assign strobe_edge = s0_q.strobe & ~s1_q;

    // A new operation (from IDLE or DONE) ignores any carry left from the last one.
    assign step_cin = (state_q == SHIFT) ? carry_q : 1'b0;
    assign step_s   = s0_q.a_bit ^ s0_q.b_bit ^ step_cin;
    assign step_c   = (s0_q.a_bit & s0_q.b_bit) | (step_cin & (s0_q.a_bit ^ s0_q.b_bit));

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        s0_d        = in_pre;
        s1_d        = s0_q.strobe;
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        shreg_d     = shreg_q;
        uo_d        = uo_q;
        carry_out_d = carry_out_q;

        if (s0_q.clear) begin
            state_d     = IDLE;
            count_d     = '0;
            carry_d     = 1'b0;
            shreg_d     = '0;
            uo_d        = '0;
            carry_out_d = 1'b0;
        end else if (strobe_edge) begin
            shreg_d = {step_s, shreg_q[WIDTH-1:1]};
            carry_d = step_c;
            state_d = SHIFT;
            if (state_q == SHIFT) count_d = count_q + 4'd1;
            else                  count_d = 4'd1;

            if (state_q == SHIFT && count_d == 4'(WIDTH)) begin
                state_d            = DONE;
                uo_d               = '0;
                uo_d[WIDTH-1:0]    = shreg_d;
                carry_out_d        = step_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q        <= '0;
            s1_q        <= 1'b0;
            state_q     <= IDLE;
            count_q     <= '0;
            carry_q     <= 1'b0;
            shreg_q     <= '0;
            uo_q        <= '0;
            carry_out_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            shreg_q     <= shreg_d;
            uo_q        <= uo_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = {5'b0, state_q == SHIFT, state_q == DONE, carry_out_q};
    assign uio_oe  = 8'h07;

    logic unused_inputs;
    assign unused_inputs = &{ena, ui_in[7:4], uio_in, 1'b0};

endmodule

// File: tb/tb_tt_um_serial_sum.sv
// Scoreboard bench for tt_um_serial_sum: stimulus pushes expected results,
// monitors pop and compare on each rising done of the WIDTH=8 and WIDTH=4 instances.
module tb_tt_um_serial_sum;

    typedef struct {
        logic [7:0] uo;
        logic       carry;
    } exp_t;

`ifdef SERIAL_SUM_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] ui8 = 8'h00, ui4 = 8'h00;
    logic [7:0] uo8, uio_out8, oe8;
    logic [7:0] uo4, uio_out4, oe4;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    tt_um_serial_sum #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui8), .uo_out(uo8),
        .uio_in(uio_in), .uio_out(uio_out8), .uio_oe(oe8)
    );

    tt_um_serial_sum #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui4), .uo_out(uo4),
        .uio_in(uio_in), .uio_out(uio_out4), .uio_oe(oe4)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit is4, input logic [3:0] v);
        if (is4) ui4 = {4'b0, v};
        else     ui8 = {4'b0, v};
    endtask

    task automatic send_bit(input logic a, input logic b, input bit is4, input int hold, input logic clr);
        @(negedge clk);
        drive(is4, {clr, 1'b1, b, a});
        repeat (hold) @(negedge clk);
        drive(is4, 4'b0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit is4,
                          input int hold, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(a[i], b[i], is4, hold, 1'b0);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    // Monitors: one pop per rising edge of done.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (uio_out8[1] && !prev) begin
                if (q8.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done8_unexpected: got completion uo=%h, expected none", uo8);
                end else begin
                    e = q8.pop_front();
                    check("result8", {uo8, uio_out8}, {e.uo, 5'b0, 1'b0, 1'b1, e.carry});
                end
            end
            prev = uio_out8[1];
        end
    end

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (uio_out4[1] && !prev) begin
                if (q4.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done4_unexpected: got completion uo=%h, expected none", uo4);
                end else begin
                    e = q4.pop_front();
                    check("result4", {uo4, uio_out4}, {e.uo, 5'b0, 1'b0, 1'b1, e.carry});
                end
            end
            prev = uio_out4[1];
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_uo8", {8'h0, uo8}, 16'h0000);
        check("rst_uio8", {8'h0, uio_out8}, 16'h0000);
        check("rst_oe8", {8'h0, oe8}, 16'h0007);
        check("rst_uo4", {8'h0, uo4}, 16'h0000);
        rst_n = 1'b1;
        settle();

        // 0x5A + 0x3C = 0x096; last bit sent by hand to measure completion latency.
        q8.push_back('{uo: 8'h96, carry: 1'b0});
        run_op(8'h5A, 8'h3C, 1'b0, 1, 0, 6);
        @(negedge clk);
        drive(1'b0, 4'b0100);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 4'b0);
            if (k == LAT - 1) check("done_not_early", {15'b0, uio_out8[1]}, 16'h0000);
            if (k == LAT) check("done_on_time", {15'b0, uio_out8[1]}, 16'h0001);
        end
        settle();
        check("t1_uo", {8'h0, uo8}, 16'h0096);
        check("t1_uio", {8'h0, uio_out8}, 16'h0002);
        check("t1_oe", {8'h0, oe8}, 16'h0007);

        // 0xFF + 0x01 = 0x100, then 0+0 restarted straight from DONE.
        q8.push_back('{uo: 8'h00, carry: 1'b1});
        run_op(8'hFF, 8'h01, 1'b0, 1, 0, 7);
        settle();
        check("t2_uio", {8'h0, uio_out8}, 16'h0003);
        q8.push_back('{uo: 8'h00, carry: 1'b0});
        send_bit(1'b0, 1'b0, 1'b0, 1, 1'b0);
        settle();
        check("t2_done_drop", {8'h0, uio_out8}, 16'h0005);
        run_op(8'h00, 8'h00, 1'b0, 1, 1, 7);
        settle();
        check("t2b_uo", {8'h0, uo8}, 16'h0000);
        check("t2b_uio", {8'h0, uio_out8}, 16'h0002);

        // Three bits of 0xF0 + 0x0F, then clear coincident with the fourth strobe.
        run_op(8'hF0, 8'h0F, 1'b0, 1, 0, 2);
        send_bit(1'b0, 1'b1, 1'b0, 1, 1'b1);
        settle();
        check("t3_clear_uo", {8'h0, uo8}, 16'h0000);
        check("t3_clear_uio", {8'h0, uio_out8}, 16'h0000);
        q8.push_back('{uo: 8'hFF, carry: 1'b0});
        run_op(8'hF0, 8'h0F, 1'b0, 1, 0, 7);
        settle();
        check("t3_uo", {8'h0, uo8}, 16'h00FF);

        // Strobe held high 20 cycles per bit: 0x80 + 0x80 = 0x100.
        q8.push_back('{uo: 8'h00, carry: 1'b1});
        run_op(8'h80, 8'h80, 1'b0, 20, 0, 7);
        settle();
        check("t4_uio", {8'h0, uio_out8}, 16'h0003);

        // Asynchronous reset during bit 5, away from any clock edge.
        run_op(8'hAA, 8'h55, 1'b0, 1, 0, 4);
        settle();
        check("t5_busy_before", {8'h0, uio_out8}, 16'h0005);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_uo", {8'h0, uo8}, 16'h0000);
        check("t5_rst_uio", {8'h0, uio_out8}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        q8.push_back('{uo: 8'h46, carry: 1'b0});
        run_op(8'h12, 8'h34, 1'b0, 1, 0, 7);
        settle();
        check("t5_uo", {8'h0, uo8}, 16'h0046);

        // WIDTH=4: 0xF + 0x3 = 0x12 -> low nibble 2, carry 1, upper bits zero.
        q4.push_back('{uo: 8'h02, carry: 1'b1});
        run_op(8'h0F, 8'h03, 1'b1, 1, 0, 3);
        settle();
        check("t6_uo4", {8'h0, uo4}, 16'h0002);
        check("t6_uio4", {8'h0, uio_out4}, 16'h0003);
        check("t6_oe4", {8'h0, oe4}, 16'h0007);

        settle();
        check("q8_drained", 16'(q8.size()), 16'h0000);
        check("q4_drained", 16'(q4.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
